// File: rtl/key_debounce_multi_pkg.sv
// rtl/key_debounce_multi_pkg.sv - shared types for the multi-channel key debouncer
package key_debounce_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } deb_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce_multi_ch.sv
// rtl/key_debounce_multi_ch.sv - one key channel: 2-FF sync, press/release debounce, long-press strobe
module key_debounce_multi_ch
    import key_debounce_multi_pkg::*;
#(
    parameter int ACT_LOW  = 0,
    parameter int DEB_CNT  = 10,
    parameter int DEB_W    = 4,
    parameter int LONG_CNT = 200,
    parameter int LONG_W   = 8
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic tick_en,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic              INV_BIT   = ACT_LOW[0];
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'((LONG_CNT == 0) ? 0 : LONG_CNT - 1);
    localparam logic              LONG_EN   = (LONG_CNT != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw;
    deb_state_e             state;
    logic [DEB_W-1:0]       deb_cnt;
    logic [LONG_W-1:0]      hold_cnt;
    logic                   long_done;

    // Sync FFs reset to the electrically idle level so raw starts inactive.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {SYNC_STAGES{INV_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
        end
    end

    assign raw = sync_q[SYNC_STAGES-1] ^ INV_BIT;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (raw) begin
                        state   <= ST_PRESS_CHK;
                        deb_cnt <= '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!raw) begin
                        state   <= ST_IDLE;
                        deb_cnt <= '0;
                    end else if (tick_en) begin
                        if (deb_cnt == DEB_LAST) begin
                            state     <= ST_HELD;
                            deb_cnt   <= '0;
                            hold_cnt  <= '0;
                            long_done <= 1'b0;
                            key_level <= 1'b1;
                            key_press <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!raw) begin
                        state   <= ST_REL_CHK;
                        deb_cnt <= '0;
                    end else if (tick_en && !long_done && LONG_EN) begin
                        // hold_cnt stays frozen once long_done is set, so it never wraps
                        if (hold_cnt == LONG_LAST) begin
                            key_long  <= 1'b1;
                            long_done <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_REL_CHK: begin
                    if (raw) begin
                        state   <= ST_HELD;
                        deb_cnt <= '0;
                    end else if (tick_en) begin
                        if (deb_cnt == DEB_LAST) begin
                            state       <= ST_IDLE;
                            deb_cnt     <= '0;
                            hold_cnt    <= '0;
                            long_done   <= 1'b0;
                            key_level   <= 1'b0;
                            key_release <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    deb_cnt   <= '0;
                    hold_cnt  <= '0;
                    long_done <= 1'b0;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N independent debounced key channels on a shared tick
module key_debounce_multi
    import key_debounce_multi_pkg::*;
#(
    parameter int N_KEYS   = 4,
    parameter int ACT_LOW  = 0,
    parameter int DEB_CNT  = 10,
    parameter int DEB_W    = 4,
    parameter int LONG_CNT = 200,
    parameter int LONG_W   = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              tick_en,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_multi_ch #(
            .ACT_LOW  (ACT_LOW),
            .DEB_CNT  (DEB_CNT),
            .DEB_W    (DEB_W),
            .LONG_CNT (LONG_CNT),
            .LONG_W   (LONG_W)
        ) u_ch (
            .clk         (clk),
            .sys_rst_n   (sys_rst_n),
            .tick_en     (tick_en),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule
